store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: WIDTH, 32, data and address width in bits; only 32 is supported.
REQ-002 Parameter: DEPTH, 4, number of buffer entries; power of two, at least 2.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 Port: st_valid  input  1  store request from core.
REQ-006 Port: st_ready  output  1  buffer can accept a store.
REQ-007 Port: st_addr  input  WIDTH  byte address of store.
REQ-008 Port: st_data  input  WIDTH  store data, right-aligned (bits [7:0] for byte, [15:0] for half).
REQ-009 Port: st_size  input  2  00 byte, 01 half, 10 word; 11 is reserved and treated as misaligned.
REQ-010 Port: mem_we  output  1  data-memory write strobe.
REQ-011 Port: mem_addr  output  WIDTH  word-aligned write address, bits [1:0] = 00.
REQ-012 Port: mem_wdata  output  WIDTH  lane-aligned write data.
REQ-013 Port: mem_be  output  4  byte enables; bit i enables bits [8i+7:8i].
REQ-014 Port: mem_ack  input  1  memory accepts the current write this cycle.
REQ-015 Port: ld_addr  input  WIDTH  address of the load for forwarding lookup.
REQ-016 Port: ld_hit_be  output  4  bytes of the ld_addr word held in the buffer.
REQ-017 Port: ld_data  output  WIDTH  forwarded word; only bytes with ld_hit_be set are valid.
REQ-018 Port: count  output  log2(DEPTH)+1  number of valid entries.
REQ-019 Port: err_misaligned  output  1  one-cycle pulse flagging a dropped misaligned store.

Function
REQ-020 st_ready SHALL equal (count != DEPTH) and SHALL not depend on st_valid.
- A store SHALL be accepted on a rising edge where st_valid and st_ready are both 1.
- There is no bypass: a store is refused when the buffer is full, even if a pop occurs in the same cycle.
REQ-021 Lane alignment at enqueue: byte data SHALL be replicated to all four lanes.
- Byte: be = 1 << addr[1:0].
- Half: data replicated to both halves; be = 0011 when addr[1]=0, 1100 when addr[1]=1.
- Word: be = 1111.
REQ-022 Misaligned stores SHALL complete the handshake, not be enqueued, and pulse err_misaligned for exactly the following cycle. Misaligned means any of:
- half with addr[0]=1;
- word with addr[1:0] != 00;
- size = 11.
REQ-023 Entries SHALL form a FIFO with circular head and tail pointers that wrap modulo DEPTH; memory writes retire strictly in acceptance order.
REQ-024 The drain FSM SHALL have two states, IDLE and WRITE.
- IDLE -> WRITE on a rising edge where count != 0; mem_addr, mem_wdata and mem_be are loaded from the head entry on that edge.
- WRITE: mem_we = 1. On mem_ack the head entry is popped, and the FSM either loads the next entry (stays in WRITE) if count after the pop is nonzero, or returns to IDLE.
- Without mem_ack the FSM SHALL hold WRITE with mem_addr, mem_wdata and mem_be stable.
REQ-025 Latency: a store accepted at edge N into an empty buffer SHALL produce mem_we=1 in the cycle after edge N+1. Back-to-back stores with mem_ack held at 1 SHALL retire one per cycle.
REQ-026 count SHALL update each edge as count + push - pop; a simultaneous push and pop leaves count unchanged.
REQ-027 Forwarding SHALL be combinational over all valid entries, including the one being written.
- An entry matches when its word address equals ld_addr[31:2].
- Per byte, the youngest matching entry enabling that byte SHALL supply ld_data.
- Non-hit bytes of ld_data SHALL be 0.
- The store being accepted in the same cycle SHALL NOT be visible.

Reset
REQ-028 While rst=0, the block SHALL hold:
- count = 0, head = tail = 0, FSM = IDLE;
- mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0;
- err_misaligned = 0, st_ready = 0, ld_hit_be = 0.
REQ-029 Reset asserted mid-WRITE SHALL discard all pending entries immediately, with no completion of the in-flight write. st_ready SHALL rise in the first cycle after rst returns to 1.

Configuration
REQ-030 Macro STORE_BUFFER_FWD_EN controls forwarding.
- Defined: REQ-027 forwarding is compiled in.
- Undefined: no comparators are built, and ld_hit_be and ld_data are tied to 0; all other behaviour is identical.

Verification
REQ-031 Single store, mem_ack held at 1.
- Stimulus: sw 0xDEADBEEF to 0x00000104.
- Response: one cycle with mem_we=1, mem_addr=0x104, mem_be=1111, mem_wdata=0xDEADBEEF; count returns to 0.
REQ-032 Byte store lane alignment.
- Stimulus: sb 0x000000AB to 0x00000203.
- Response: mem_addr=0x200, mem_be=1000, mem_wdata=0xABABABAB.
REQ-033 Fill and stall.
- Stimulus: mem_ack=0, five sw pushed with DEPTH=4.
- Response: st_ready=0 after the fourth store and count=4. After mem_ack is raised, four writes retire in order and the fifth store is then accepted.
REQ-034 Misaligned store.
- Stimulus: sh to 0x00000101.
- Response: handshake completes, err_misaligned=1 for one cycle, count stays 0, no mem_we.
REQ-035 Forwarding, with STORE_BUFFER_FWD_EN defined and mem_ack=0.
- Stimulus: sw 0x11223344 then sb 0x55 to 0x300, with ld_addr=0x300.
- Response: ld_hit_be=1111, ld_data=0x11223355.
- With the macro undefined: ld_hit_be=0000.
REQ-036 Reset mid-WRITE.
- Stimulus: three entries queued, mem_ack=0, rst pulled low.
- Response: same cycle mem_we=0 and count=0; no further writes occur after release.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: in-order store buffer sitting between the core and data memory.
// Stores are lane-aligned on entry and kept in a circular FIFO. A two-state
// drain FSM (IDLE/WRITE) writes them to memory one at a time. Loads can
// forward bytes from pending stores; the youngest store wins per byte.
// Optional feature macro: STORE_BUFFER_FWD_EN (builds the forwarding
// comparators; without it ld_hit_be and ld_data are tied to zero).
module store_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [WIDTH-1:0]         st_addr,
  input  logic [WIDTH-1:0]         st_data,
  input  logic [1:0]               st_size,
  output logic                     mem_we,
  output logic [WIDTH-1:0]         mem_addr,
  output logic [WIDTH-1:0]         mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_ack,
  input  logic [WIDTH-1:0]         ld_addr,
  output logic [3:0]               ld_hit_be,
  output logic [WIDTH-1:0]         ld_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_misaligned
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  logic [WIDTH-3:0] ent_addr_q [DEPTH];
  logic [WIDTH-1:0] ent_data_q [DEPTH];
  logic [3:0]       ent_be_q   [DEPTH];

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, head_nxt;
  logic [CW-1:0]    count_q, count_d;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic             err_q;

  logic [3:0]       al_be;
  logic [WIDTH-1:0] al_data;
  logic             misaligned, accept, push, pop;

  assign st_ready       = rst && (count_q != CW'(DEPTH));
  assign accept         = st_valid && st_ready;
  assign push           = accept && !misaligned;
  assign pop            = (state_q == WRITE) && mem_ack;
  assign count_d        = count_q + CW'(push) - CW'(pop);
  assign head_nxt       = head_q + PW'(1);
  assign head_d         = pop  ? head_nxt : head_q;
  assign tail_d         = push ? tail_q + PW'(1) : tail_q;
  assign mem_we         = (state_q == WRITE);
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_be         = mem_be_q;
  assign count          = count_q;
  assign err_misaligned = err_q;

  // Lane-align the incoming store and flag illegal size/address combinations
  always_comb begin
    al_be      = 4'b0000;
    al_data    = st_data;
    misaligned = 1'b0;
    case (st_size)
      2'b00: begin
        al_be   = 4'b0001 << st_addr[1:0];
        al_data = {4{st_data[7:0]}};
      end
      2'b01: begin
        al_be      = st_addr[1] ? 4'b1100 : 4'b0011;
        al_data    = {2{st_data[15:0]}};
        misaligned = st_addr[0];
      end
      2'b10: begin
        al_be      = 4'b1111;
        misaligned = (st_addr[1:0] != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Drain FSM: choose the next memory write; when the last entry pops while a
  // new store arrives, the incoming store is loaded directly
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d     = WRITE;
          mem_addr_d  = {ent_addr_q[head_q], 2'b00};
          mem_wdata_d = ent_data_q[head_q];
          mem_be_d    = ent_be_q[head_q];
        end
      end
      WRITE: begin
        if (mem_ack) begin
          if (count_d == '0) begin
            state_d = IDLE;
          end else if (count_q > CW'(1)) begin
            mem_addr_d  = {ent_addr_q[head_nxt], 2'b00};
            mem_wdata_d = ent_data_q[head_nxt];
            mem_be_d    = ent_be_q[head_nxt];
          end else begin
            mem_addr_d  = {st_addr[WIDTH-1:2], 2'b00};
            mem_wdata_d = al_data;
            mem_be_d    = al_be;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and memory-port registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      err_q       <= accept && misaligned;
    end
  end

  // Entry storage is written at the tail; validity is tracked by count_q only
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[tail_q] <= st_addr[WIDTH-1:2];
      ent_data_q[tail_q] <= al_data;
      ent_be_q[tail_q]   <= al_be;
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] fwd_idx;
  logic          ld_unused;
  assign ld_unused = ^ld_addr[1:0];

  // Forwarding: walk oldest to youngest so younger matches overwrite bytes
  always_comb begin
    ld_hit_be = 4'b0000;
    ld_data   = '0;
    fwd_idx   = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (ent_addr_q[fwd_idx] == ld_addr[WIDTH-1:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (ent_be_q[fwd_idx][b]) begin
            ld_hit_be[b]     = 1'b1;
            ld_data[8*b +: 8] = ent_data_q[fwd_idx][8*b +: 8];
          end
        end
      end
    end
  end
`else
  logic ld_unused;
  assign ld_unused = ^ld_addr;
  assign ld_hit_be = 4'b0000;
  assign ld_data   = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios plus a random phase. A negedge monitor
// keeps a queue of pending stores, predicts each memory write, count,
// st_ready, err_misaligned and forwarded load data, and compares.
module tb_store_buffer;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic [3:0]  ld_hit_be;
  logic [31:0] ld_data;
  logic [2:0]  count;
  logic        err_misaligned;

  int   errors = 0;
  int   checks = 0;
  ent_t pend[$];
  logic err_exp = 1'b0;

  store_buffer #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_size(st_size),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack),
    .ld_addr(ld_addr), .ld_hit_be(ld_hit_be), .ld_data(ld_data),
    .count(count), .err_misaligned(err_misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference lane placement taken straight from the store-size rules
  function automatic void ref_align(input logic [31:0] a, input logic [31:0] d,
                                    input logic [1:0] sz, output ent_t e,
                                    output logic mis);
    int lane;
    lane = int'(a[1:0]);
    e.a  = {a[31:2], 2'b00};
    e.d  = 32'h0;
    e.be = 4'h0;
    mis  = 1'b0;
    if (sz == 2'd0) begin
      for (int k = 0; k < 4; k++) e.d[8*k +: 8] = d[7:0];
      e.be[lane] = 1'b1;
    end else if (sz == 2'd1) begin
      mis  = (lane % 2) != 0;
      e.d  = (d & 32'hFFFF) * 32'h0001_0001;
      e.be = (lane >= 2) ? 4'hC : 4'h3;
    end else if (sz == 2'd2) begin
      mis  = lane != 0;
      e.d  = d;
      e.be = 4'hF;
    end else begin
      mis = 1'b1;
    end
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    ent_t        e;
    logic        mis, exp_ready, err_nxt;
    logic [3:0]  fhit;
    logic [31:0] fdat;
    if (!rst) begin
      chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
      chk("rst_count", {29'h0, count}, 32'h0);
      chk("rst_st_ready", {31'h0, st_ready}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
      chk("rst_err", {31'h0, err_misaligned}, 32'h0);
      chk("rst_ld_hit", {28'h0, ld_hit_be}, 32'h0);
      pend.delete();
      err_exp = 1'b0;
    end else begin
      exp_ready = (pend.size() != DEPTH);
      chk("st_ready", {31'h0, st_ready}, {31'h0, exp_ready});
      chk("count", {29'h0, count}, pend.size());
      chk("err_misaligned", {31'h0, err_misaligned}, {31'h0, err_exp});
      fhit = 4'h0;
      fdat = 32'h0;
`ifdef STORE_BUFFER_FWD_EN
      foreach (pend[i]) begin
        if (pend[i].a[31:2] == ld_addr[31:2]) begin
          for (int b = 0; b < 4; b++) begin
            if (pend[i].be[b]) begin
              fhit[b] = 1'b1;
              fdat[8*b +: 8] = pend[i].d[8*b +: 8];
            end
          end
        end
      end
`endif
      chk("ld_hit_be", {28'h0, ld_hit_be}, {28'h0, fhit});
      chk("ld_data", ld_data, fdat);
      if (mem_we) begin
        if (pend.size() == 0) begin
          chk("write_without_pending", 32'h1, 32'h0);
        end else begin
          chk("mem_addr", mem_addr, pend[0].a);
          chk("mem_wdata", mem_wdata, pend[0].d);
          chk("mem_be", {28'h0, mem_be}, {28'h0, pend[0].be});
          if (mem_ack) void'(pend.pop_front());
        end
      end
      err_nxt = 1'b0;
      if (st_valid && exp_ready) begin
        ref_align(st_addr, st_data, st_size, e, mis);
        if (mis) err_nxt = 1'b1;
        else pend.push_back(e);
      end
      err_exp = err_nxt;
    end
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = sz;
    @(posedge clk);
    #1 st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (count == 3'd0 && !mem_we) done = 1'b1;
    end
    chk(nm, {31'h0, done}, 32'h1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = 2'd0;
    mem_ack = 1'b0; ld_addr = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Single word store, ack held high: latency and retire
    mem_ack = 1'b1;
    @(posedge clk); #1;
    store(32'h0000_0104, 32'hDEAD_BEEF, 2'd2);
    @(negedge clk);
    chk("sw_lat_we0", {31'h0, mem_we}, 32'h0);
    chk("sw_lat_cnt1", {29'h0, count}, 32'h1);
    @(negedge clk);
    chk("sw_we", {31'h0, mem_we}, 32'h1);
    chk("sw_addr", mem_addr, 32'h0000_0104);
    chk("sw_be", {28'h0, mem_be}, 32'hF);
    chk("sw_data", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("sw_done_we", {31'h0, mem_we}, 32'h0);
    chk("sw_done_cnt", {29'h0, count}, 32'h0);

    // Byte store lane alignment
    @(posedge clk); #1;
    store(32'h0000_0203, 32'h0000_00AB, 2'd0);
    @(negedge clk);
    @(negedge clk);
    chk("sb_addr", mem_addr, 32'h0000_0200);
    chk("sb_be", {28'h0, mem_be}, 32'h8);
    chk("sb_data", mem_wdata, 32'hABAB_ABAB);
    wait_empty("sb_drain");

    // Fill and stall
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) store(32'h400 + 32'(4 * k), 32'hA000_0000 + 32'(k), 2'd2);
    st_valid = 1'b1; st_addr = 32'h410; st_data = 32'hA000_0004; st_size = 2'd2;
    @(negedge clk);
    chk("fill_ready0", {31'h0, st_ready}, 32'h0);
    chk("fill_cnt4", {29'h0, count}, 32'h4);
    repeat (2) @(negedge clk);
    chk("stall_cnt4", {29'h0, count}, 32'h4);
    @(posedge clk); #1 mem_ack = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (st_ready) begin
        @(posedge clk);
        #1 st_valid = 1'b0;
        acc = 1'b1;
      end
    end
    chk("fifth_accepted", {31'h0, acc}, 32'h1);
    st_valid = 1'b0;
    wait_empty("fill_drain");

    // Misaligned half store
    @(posedge clk); #1;
    store(32'h0000_0101, 32'h0000_1234, 2'd1);
    @(negedge clk);
    chk("mis_err1", {31'h0, err_misaligned}, 32'h1);
    chk("mis_cnt0", {29'h0, count}, 32'h0);
    @(negedge clk);
    chk("mis_err0", {31'h0, err_misaligned}, 32'h0);
    chk("mis_no_we", {31'h0, mem_we}, 32'h0);

    // Forwarding with drain stalled
    @(posedge clk); #1;
    mem_ack = 1'b0;
    ld_addr = 32'h0000_0300;
    store(32'h0000_0300, 32'h1122_3344, 2'd2);
    store(32'h0000_0300, 32'h0000_0055, 2'd0);
    @(negedge clk);
`ifdef STORE_BUFFER_FWD_EN
    chk("fwd_hit", {28'h0, ld_hit_be}, 32'hF);
    chk("fwd_data", ld_data, 32'h1122_3355);
`else
    chk("fwd_hit_off", {28'h0, ld_hit_be}, 32'h0);
    chk("fwd_data_off", ld_data, 32'h0);
`endif

    // Reset in the middle of a stalled write with three entries queued
    @(posedge clk); #1;
    store(32'h0000_0308, 32'h0BAD_F00D, 2'd2);
    @(negedge clk);
    chk("pre_rst_cnt3", {29'h0, count}, 32'h3);
    chk("pre_rst_we", {31'h0, mem_we}, 32'h1);
    @(posedge clk); #3 rst = 1'b0;
    #1;
    chk("rst_now_we", {31'h0, mem_we}, 32'h0);
    chk("rst_now_cnt", {29'h0, count}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, st_ready}, 32'h1);
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_we", {31'h0, mem_we}, 32'h0);
    end

    // Random traffic around a small address window so forwarding hits often
    @(posedge clk); #1;
    for (int c = 0; c < 400; c++) begin
      st_valid = ($urandom_range(0, 2) != 0);
      st_addr  = 32'h0000_0500 + 32'($urandom_range(0, 15));
      st_data  = $urandom;
      st_size  = 2'($urandom_range(0, 3));
      mem_ack  = ($urandom_range(0, 2) == 0);
      ld_addr  = 32'h0000_0500 + 32'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    st_valid = 1'b0;
    mem_ack  = 1'b1;
    wait_empty("rand_drain");
    @(negedge clk);
    chk("final_pending", pend.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
